// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns the MEM stage's single-cycle data access into a
// request/grant/response bus transaction and stalls the pipeline until the
// response (or a timeout) completes it. Read data is valid in the DONE cycle,
// so the MEM/WB register captures it on the edge that ends the stall.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        err_flag
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  // Last counter value before an unanswered transaction is force-completed.
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [9:0]  r_tmo_cnt;
  logic        w_tmo_hit;
  logic        w_resp;
  logic        w_tmo_done;
  logic        w_start;

  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [31:0] r_cpu_rdata;
  logic        r_err_flag;

  assign w_start   = (r_state == IDLE) && cpu_req;
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  // Next-state decode; a response in the timeout cycle takes priority.
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    w_tmo_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req) w_state_nxt = REQ;
      end
      REQ: begin
        if (bus_gnt && bus_rvalid) begin
          w_resp      = 1'b1;
          w_state_nxt = DONE;
        end else if (w_tmo_hit) begin
          w_tmo_done  = 1'b1;
          w_state_nxt = DONE;
        end else if (bus_gnt) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          w_resp      = 1'b1;
          w_state_nxt = DONE;
        end else if (w_tmo_hit) begin
          w_tmo_done  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // The instruction advances on this edge, so never chain directly.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Timeout counter: cleared on request entry, counts every REQ/WAIT cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tmo_cnt <= 10'd0;
    end else if (w_start) begin
      r_tmo_cnt <= 10'd0;
    end else if ((r_state == REQ) || (r_state == WAIT)) begin
      r_tmo_cnt <= r_tmo_cnt + 10'd1;
    end
  end

  // Latch the request once; the bus fields stay frozen until the next request.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_be    <= 4'd0;
    end else if (w_start) begin
      r_bus_we    <= cpu_we;
      r_bus_addr  <= cpu_addr & 32'hFFFF_FFFC;
      r_bus_wdata <= cpu_wdata;
      r_bus_be    <= cpu_be;
    end
  end

  // Response capture: reads update cpu_rdata, errors and timeouts set the
  // sticky flag; stores leave cpu_rdata untouched.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cpu_rdata <= 32'd0;
      r_err_flag  <= 1'b0;
    end else if (w_resp) begin
      if (bus_err) r_err_flag <= 1'b1;
      if (!r_bus_we) r_cpu_rdata <= bus_err ? ERR_RDATA : bus_rdata;
    end else if (w_tmo_done) begin
      r_err_flag <= 1'b1;
      if (!r_bus_we) r_cpu_rdata <= ERR_RDATA;
    end
  end

  assign bus_req   = (r_state == REQ);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;
  assign cpu_rdata = r_cpu_rdata;
  assign err_flag  = r_err_flag;
  // Includes the IDLE cycle a request first appears, so nothing slips past.
  assign stall     = cpu_req && (r_state != DONE);

endmodule
